// File: rtl/aes128_key_sched_seq_if.sv
// Round-key stream bundle between the key schedule (slave) and its driver/consumer (master).
interface aes128_key_sched_seq_if;
    logic         start;
    logic [127:0] key_in;
    logic         busy;
    logic         rk_valid;
    logic         rk_ready;
    logic [127:0] rk_out;
    logic [3:0]   rk_idx;
    logic         rk_last;
    logic         done;

    modport master (
        output start, key_in, rk_ready,
        input  busy, rk_valid, rk_out, rk_idx, rk_last, done
    );

    modport slave (
        input  start, key_in, rk_ready,
        output busy, rk_valid, rk_out, rk_idx, rk_last, done
    );
endinterface

// File: rtl/aes128_key_sched_seq.sv
// Sequential AES-128 key expansion: one FIPS-197 step per accepted round key, 11 keys per schedule.
//   state | meaning
//   IDLE  | no schedule running, waiting for start
//   EMIT  | rk_out/rk_idx hold a valid round key, advance on handshake
module aes128_key_sched_seq (
    input  logic                         clk,
    input  logic                         rst,
    aes128_key_sched_seq_if.slave        ks
);
    typedef enum logic {IDLE, EMIT} state_t;

    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    state_t         state_q, state_d;
    logic [127:0]   rk_q, rk_d;
    logic [3:0]     idx_q, idx_d;
    logic           done_q, done_d;

    logic [3:0]     idx_inc;
    logic [7:0]     rcon;
    logic [31:0]    rot_w3, t_word;
    logic [31:0]    w0_n, w1_n, w2_n, w3_n;
    logic [127:0]   rk_next;

    assign idx_inc = idx_q + 4'd1;

    always_comb begin
        rcon = 8'h00;
        case (idx_inc)
            4'd1:    rcon = 8'h01;
            4'd2:    rcon = 8'h02;
            4'd3:    rcon = 8'h04;
            4'd4:    rcon = 8'h08;
            4'd5:    rcon = 8'h10;
            4'd6:    rcon = 8'h20;
            4'd7:    rcon = 8'h40;
            4'd8:    rcon = 8'h80;
            4'd9:    rcon = 8'h1b;
            4'd10:   rcon = 8'h36;
            default: rcon = 8'h00;
        endcase
    end

    // SubWord(RotWord(w3)) ^ rcon, then the chained word XORs of one expansion step
    assign rot_w3  = {rk_q[23:0], rk_q[31:24]};
    assign t_word  = {SBOX[rot_w3[31:24]] ^ rcon, SBOX[rot_w3[23:16]],
                      SBOX[rot_w3[15:8]], SBOX[rot_w3[7:0]]};
    assign w0_n    = rk_q[127:96] ^ t_word;
    assign w1_n    = rk_q[95:64]  ^ w0_n;
    assign w2_n    = rk_q[63:32]  ^ w1_n;
    assign w3_n    = rk_q[31:0]   ^ w2_n;
    assign rk_next = {w0_n, w1_n, w2_n, w3_n};

    always_comb begin
        state_d = state_q;
        rk_d    = rk_q;
        idx_d   = idx_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (ks.start) begin
                    rk_d    = ks.key_in;
                    idx_d   = 4'd0;
                    state_d = EMIT;
                end
            end
            EMIT: begin
                if (ks.rk_ready) begin
                    if (idx_q == 4'd10) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        rk_d  = rk_next;
                        idx_d = idx_inc;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            rk_q    <= '0;
            idx_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rk_q    <= rk_d;
            idx_q   <= idx_d;
            done_q  <= done_d;
        end
    end

    assign ks.busy     = (state_q == EMIT);
    assign ks.rk_valid = (state_q == EMIT);
    assign ks.rk_out   = rk_q;
    assign ks.rk_idx   = idx_q;
    assign ks.rk_last  = (state_q == EMIT) && (idx_q == 4'd10);
    assign ks.done     = done_q;
endmodule

// File: tb/tb_aes128_key_sched_seq.sv
// Bench for aes128_key_sched_seq: FIPS-197 known answers, backpressure, ignored starts, reset, random keys.
module tb_aes128_key_sched_seq;
    logic clk;
    logic rst;
    aes128_key_sched_seq_if ks();

    aes128_key_sched_seq dut (.clk(clk), .rst(rst), .ks(ks));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [7:0]   sb [256];
    logic [127:0] exp_keys [11];
    logic [127:0] got_keys [11];

    typedef struct {
        logic [127:0] key;
        logic [127:0] exp1;
        logic [127:0] exp10;
    } kat_t;
    kat_t kats [2];

    localparam logic [127:0] KEY_C1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] KEY_A1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Reference S-box from the GF(2^8) inverse and affine map, not from a table
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int s);
        return (v << s) | (v >> (8 - s));
    endfunction

    task automatic build_sbox();
        for (int x = 0; x < 256; x++) begin
            logic [7:0] inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sb[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    task automatic model_expand(input logic [127:0] key);
        logic [31:0] w [44];
        logic [31:0] tmp;
        logic [7:0]  rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = {tmp[23:0], tmp[31:24]};
                tmp = {sb[tmp[31:24]], sb[tmp[23:16]], sb[tmp[15:8]], sb[tmp[7:0]]} ^ {rc, 24'h0};
                rc  = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ tmp;
        end
        for (int r = 0; r < 11; r++) exp_keys[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    // Entered and left at a negedge; start is driven in the calling cycle.
    task automatic run_sched(input logic [127:0] key, input int pct, input logic poke);
        int n = 0;
        int edges = 0;
        logic r;
        model_expand(key);
        ks.start  = 1'b1;
        ks.key_in = key;
        @(posedge clk);
        @(negedge clk);
        ks.start  = 1'b0;
        ks.key_in = {$urandom, $urandom, $urandom, $urandom};
        while (n < 11 && edges < 3000) begin
            chk("rk_valid", 128'(ks.rk_valid), 128'(1));
            chk("busy", 128'(ks.busy), 128'(1));
            chk("rk_idx", 128'(ks.rk_idx), 128'(n));
            chk("rk_out", ks.rk_out, exp_keys[n]);
            chk("rk_last", 128'(ks.rk_last), 128'(n == 10));
            chk("done_low", 128'(ks.done), 128'(0));
            r = ($urandom_range(0, 99) < pct);
            if (poke && n == 10) r = 1'b1;
            ks.rk_ready = r;
            if (poke && (n == 4 || n == 10)) begin
                ks.start  = 1'b1;
                ks.key_in = '1;
            end
            if (r) got_keys[n] = ks.rk_out;
            @(posedge clk);
            edges++;
            if (r) n++;
            @(negedge clk);
            ks.start    = 1'b0;
            ks.rk_ready = 1'b0;
        end
        chk("all_keys_accepted", 128'(n), 128'(11));
        chk("done_pulse", 128'(ks.done), 128'(1));
        chk("busy_drop", 128'(ks.busy), 128'(0));
        chk("valid_drop", 128'(ks.rk_valid), 128'(0));
        chk("last_drop", 128'(ks.rk_last), 128'(0));
        chk("rk_out_hold", ks.rk_out, exp_keys[10]);
        if (pct >= 100) chk("done_latency_edges", 128'(edges), 128'(11));
    endtask

    initial begin
        kats[0] = '{key: KEY_C1, exp1: 128'hd6aa74fdd2af72fadaa678f1d6ab76fe,
                    exp10: 128'h13111d7fe3944a17f307a78b4d2b30c5};
        kats[1] = '{key: KEY_A1, exp1: 128'ha0fafe1788542cb123a339392a6c7605,
                    exp10: 128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
        ks.start    = 1'b0;
        ks.key_in   = '0;
        ks.rk_ready = 1'b0;
        rst = 1'b0;
        build_sbox();
        #1 rst = 1'b1;
        #1;
        chk("rst_busy", 128'(ks.busy), 128'(0));
        chk("rst_valid", 128'(ks.rk_valid), 128'(0));
        chk("rst_out", ks.rk_out, 128'(0));
        chk("rst_idx", 128'(ks.rk_idx), 128'(0));
        chk("rst_last", 128'(ks.rk_last), 128'(0));
        chk("rst_done", 128'(ks.done), 128'(0));
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Known answers; the A.1 start lands in the C.1 done cycle
        for (int k = 0; k < 2; k++) begin
            run_sched(kats[k].key, 100, 1'b0);
            chk("kat_idx0", got_keys[0], kats[k].key);
            chk("kat_idx1", got_keys[1], kats[k].exp1);
            chk("kat_idx10", got_keys[10], kats[k].exp10);
        end
        @(negedge clk);
        chk("done_one_cycle", 128'(ks.done), 128'(0));

        run_sched(KEY_C1, 30, 1'b0);
        chk("bp_idx10", got_keys[10], kats[0].exp10);
        @(negedge clk);

        run_sched(KEY_C1, 100, 1'b1);
        chk("poke_idx10", got_keys[10], kats[0].exp10);
        @(negedge clk);
        chk("poke_stays_idle", 128'(ks.busy), 128'(0));

        // Asynchronous reset at idx 6
        ks.start  = 1'b1;
        ks.key_in = KEY_C1;
        ks.rk_ready = 1'b1;
        @(negedge clk);
        ks.start = 1'b0;
        for (int c = 0; c < 20 && ks.rk_idx != 4'd6; c++) @(negedge clk);
        chk("reach_idx6", 128'(ks.rk_idx), 128'(6));
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_busy", 128'(ks.busy), 128'(0));
        chk("mid_rst_valid", 128'(ks.rk_valid), 128'(0));
        chk("mid_rst_out", ks.rk_out, 128'(0));
        chk("mid_rst_idx", 128'(ks.rk_idx), 128'(0));
        chk("mid_rst_last", 128'(ks.rk_last), 128'(0));
        chk("mid_rst_done", 128'(ks.done), 128'(0));
        ks.rk_ready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        run_sched(KEY_C1, 100, 1'b0);
        chk("post_rst_idx1", got_keys[1], kats[0].exp1);
        chk("post_rst_idx10", got_keys[10], kats[0].exp10);

        for (int t = 0; t < 6; t++) begin
            @(negedge clk);
            run_sched({$urandom, $urandom, $urandom, $urandom}, $urandom_range(20, 100), 1'($urandom_range(0, 1)));
        end

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
